// File: rtl/tamagotchi_pkg.sv
// Shared constants and button indices for the tamagotchi pet.
// Default cycle counts derive from the 50 MHz board clock.
package tamagotchi_pkg;

  localparam int CLK_HZ  = 50_000_000;
  localparam int DEB_MS  = 20;
  localparam int HOLD_MS = 5000;

  localparam int DEB_CYCLES_DEF  = (CLK_HZ / 1000) * DEB_MS;   // 1_000_000
  localparam int HOLD_CYCLES_DEF = (CLK_HZ / 1000) * HOLD_MS;  // 250_000_000

  typedef enum logic [2:0] {
    SALUD     = 3'd0,
    ENERGIA   = 3'd1,
    HAMBRE    = 3'd2,
    DIVERSION = 3'd3,
    RESET     = 3'd4,
    TEST      = 3'd5
  } btn_idx_e;

  // The light sensor rides in the slot after the six buttons.
  localparam int IDX_LEDSIGN = 6;
  localparam int NUM_IN      = 7;

endpackage

// File: rtl/tamagotchi_btn_frontend_debounce.sv
// btn_debounce: 2-FF synchronizer plus counter debouncer for one raw input.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous raw input
//   level      : debounced level, active-high (inverted when RST_LVL=1)
//   rise       : registered one-cycle strobe on each accepted 0->1 of level
// RST_LVL is the idle level of the raw pin; an idle-high pin is treated
// as active-low and inverted after synchronization.
module btn_debounce #(
  parameter int   DEB_CYCLES = 1_000_000,
  parameter logic RST_LVL    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1, sync2;
  logic          active;
  logic [CW-1:0] cnt;

  assign active = sync2 ^ RST_LVL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_LVL;
      sync2 <= RST_LVL;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (active == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // This cycle is the DEB_CYCLES-th consecutive differing sample.
        level <= active;
        rise  <= active;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tamagotchi_btn_frontend.sv
// tamagotchi_btn_frontend: conditions the six raw pushbuttons and the light
// sensor for the control FSM.
//   clk, rst_n           : clock, async active-low reset
//   btn_*_n              : raw active-low buttons
//   ledsign_raw          : raw active-high light sensor
//   btn_salud/energia/hambre/diversion : one-cycle press pulses
//   btn_reset, btn_test  : one-cycle pulses after a continuous long hold
//   ledsign              : debounced sensor level
// Action presses are dropped while reset or test is held; reset wins over
// test, whose hold count is frozen at zero while reset is held.
module tamagotchi_btn_frontend
  import tamagotchi_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_salud_n,
  input  logic btn_energia_n,
  input  logic btn_hambre_n,
  input  logic btn_diversion_n,
  input  logic btn_reset_n,
  input  logic btn_test_n,
  input  logic ledsign_raw,
  output logic btn_salud,
  output logic btn_energia,
  output logic btn_hambre,
  output logic btn_diversion,
  output logic btn_reset,
  output logic btn_test,
  output logic ledsign
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [NUM_IN-1:0] raw, lvl, rise;

  assign raw = {ledsign_raw, btn_test_n, btn_reset_n, btn_diversion_n,
                btn_hambre_n, btn_energia_n, btn_salud_n};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_LVL    (i != IDX_LEDSIGN)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  assign ledsign = lvl[IDX_LEDSIGN];

  logic          mask;
  logic          rst_hold, tst_hold;
  logic [HW-1:0] hcnt_rst, hcnt_tst;
  logic          done_rst, done_tst;
  logic          fire_rst, fire_tst;

  assign mask     = lvl[RESET] | lvl[TEST];
  assign rst_hold = lvl[RESET];
  assign tst_hold = lvl[TEST] & ~lvl[RESET];

  // done_* remembers that this press already fired, so a saturated counter
  // (or a test count restarted after reset is let go) cannot fire twice.
  assign fire_rst = rst_hold && (hcnt_rst == HW'(HOLD_CYCLES)) && !done_rst;
  assign fire_tst = tst_hold && (hcnt_tst == HW'(HOLD_CYCLES)) && !done_tst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_salud     <= 1'b0;
      btn_energia   <= 1'b0;
      btn_hambre    <= 1'b0;
      btn_diversion <= 1'b0;
      btn_reset     <= 1'b0;
      btn_test      <= 1'b0;
      hcnt_rst      <= '0;
      hcnt_tst      <= '0;
      done_rst      <= 1'b0;
      done_tst      <= 1'b0;
    end else begin
      btn_salud     <= rise[SALUD]     & ~mask;
      btn_energia   <= rise[ENERGIA]   & ~mask;
      btn_hambre    <= rise[HAMBRE]    & ~mask;
      btn_diversion <= rise[DIVERSION] & ~mask;

      if (!rst_hold)                          hcnt_rst <= '0;
      else if (hcnt_rst != HW'(HOLD_CYCLES))  hcnt_rst <= hcnt_rst + 1'b1;

      if (!tst_hold)                          hcnt_tst <= '0;
      else if (hcnt_tst != HW'(HOLD_CYCLES))  hcnt_tst <= hcnt_tst + 1'b1;

      done_rst  <= lvl[RESET] & (done_rst | fire_rst);
      done_tst  <= lvl[TEST]  & (done_tst | fire_tst);
      btn_reset <= fire_rst;
      btn_test  <= fire_tst;
    end
  end

endmodule

// File: tb/tb_tamagotchi_btn_frontend.sv
// Bench for tamagotchi_btn_frontend with DEB_CYCLES=4, HOLD_CYCLES=20.
// Inputs are driven on the falling edge and outputs sampled on the next
// falling edge. The reference model works on per-edge sample histories:
// a level is accepted once the last DEB_CYCLES synchronized samples all
// disagree with it, and a long press fires once its held-run reaches
// HOLD_CYCLES+1 debounced cycles.
// act/obs bit order: 0 salud, 1 energia, 2 hambre, 3 diversion,
// 4 reset, 5 test, 6 ledsign (all active-high).
module tb_tamagotchi_btn_frontend;

  localparam int D = 4;
  localparam int H = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_salud_n, btn_energia_n, btn_hambre_n, btn_diversion_n;
  logic btn_reset_n, btn_test_n, ledsign_raw;
  logic btn_salud, btn_energia, btn_hambre, btn_diversion;
  logic btn_reset, btn_test, ledsign;

  always #5 clk = ~clk;

  tamagotchi_btn_frontend #(.DEB_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_salud_n     (btn_salud_n),
    .btn_energia_n   (btn_energia_n),
    .btn_hambre_n    (btn_hambre_n),
    .btn_diversion_n (btn_diversion_n),
    .btn_reset_n     (btn_reset_n),
    .btn_test_n      (btn_test_n),
    .ledsign_raw     (ledsign_raw),
    .btn_salud       (btn_salud),
    .btn_energia     (btn_energia),
    .btn_hambre      (btn_hambre),
    .btn_diversion   (btn_diversion),
    .btn_reset       (btn_reset),
    .btn_test        (btn_test),
    .ledsign         (ledsign)
  );

  logic [6:0] obs;
  assign obs = {ledsign, btn_test, btn_reset, btn_diversion,
                btn_hambre, btn_energia, btn_salud};

  int checks = 0;
  int failures = 0;
  int cyc;

  // reference model state
  bit         hist[7][$];
  bit         st[7];
  bit         st_p[7];
  int         run_r, run_t;
  bit         fired_r, fired_t;
  logic [6:0] exp_o;

  task automatic drive(input bit [6:0] act);
    btn_salud_n     = ~act[0];
    btn_energia_n   = ~act[1];
    btn_hambre_n    = ~act[2];
    btn_diversion_n = ~act[3];
    btn_reset_n     = ~act[4];
    btn_test_n      = ~act[5];
    ledsign_raw     = act[6];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin
      hist[i].delete();
      repeat (D + 2) hist[i].push_back(1'b0);
      st[i]   = 1'b0;
      st_p[i] = 1'b0;
    end
    run_r = 0; run_t = 0;
    fired_r = 1'b0; fired_t = 1'b0;
    exp_o = '0;
  endtask

  // One clock edge of the model; act is what the edge samples.
  task automatic model_edge(input bit [6:0] act);
    bit prev[7];
    bit prev2[7];
    bit flip, pr, pt;
    int sz;
    prev  = st;
    prev2 = st_p;
    for (int i = 0; i < 7; i++) begin
      hist[i].push_back(act[i]);
      if (hist[i].size() > D + 3) void'(hist[i].pop_front());
      sz = hist[i].size();
      // samples seen by the debouncer at this edge are two edges old
      flip = 1'b1;
      for (int j = 0; j < D; j++)
        if (hist[i][sz-3-j] == st[i]) flip = 1'b0;
      if (flip) st[i] = !st[i];
    end
    for (int j = 0; j < 4; j++)
      exp_o[j] = prev[j] && !prev2[j] && !prev[4] && !prev[5];
    pr = (run_r >= H + 1) && !fired_r;
    pt = (run_t >= H + 1) && !fired_t;
    fired_r = prev[4] && (fired_r || pr);
    fired_t = prev[5] && (fired_t || pt);
    exp_o[4] = pr;
    exp_o[5] = pt;
    exp_o[6] = st[6];
    run_r = st[4] ? ((run_r < 1000) ? run_r + 1 : run_r) : 0;
    run_t = (st[5] && !st[4]) ? ((run_t < 1000) ? run_t + 1 : run_t) : 0;
    st_p = prev;
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic step(input bit [6:0] act);
    drive(act);
    @(posedge clk);
    model_edge(act);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      drive(7'($urandom));
      @(negedge clk);
      checks++;
      if (obs !== 7'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", c, obs, 7'b0);
      end
    end
    drive('0);
    rst_n = 1'b1;
    cyc = -1;
    for (int c = 0; c < 8; c++) begin
      step('0);
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
    end
  endtask

  task automatic test_action();
    int n = 0, at = -1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(c < 10 ? 7'b0000001 : 7'b0);
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL action cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
      if (obs[0]) begin n++; at = cyc; end
    end
    checks++;
    if (n != 1 || at != 6) begin
      failures++;
      $display("FAIL action_timing pulses=%0d edge=%0d exp 1 pulse at edge 6", n, at);
    end
  endtask

  task automatic test_glitch();
    int n = 0, at = -1;
    bit [5:0] bounce = 6'b111101;  // act per cycle, LSB first: 1,0,1,1,1,1
    do_reset();
    for (int c = 0; c < 13; c++) begin
      step(c < 3 ? 7'b0000100 : 7'b0);
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
      if (obs[2]) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL glitch_short pulses=%0d exp 0", n);
    end
    n = 0;
    cyc = -1;
    for (int c = 0; c < 22; c++) begin
      step((c < 6) ? {4'b0, bounce[c], 2'b0} : ((c < 16) ? 7'b0000100 : 7'b0));
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
      if (obs[2]) begin n++; at = cyc; end
    end
    checks++;
    if (n != 1 || at != 8) begin
      failures++;
      $display("FAIL bounce_timing pulses=%0d edge=%0d exp 1 pulse at edge 8", n, at);
    end
  endtask

  task automatic test_long_press();
    int dur[3]   = '{30, 15, 60};
    int exp_n[3] = '{1, 0, 1};
    int n, at;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      n = 0; at = -1; cyc = -1;
      for (int c = 0; c < dur[p] + 10; c++) begin
        step(c < dur[p] ? 7'b0100000 : 7'b0);
        checks++;
        if (obs !== exp_o) begin
          failures++;
          $display("FAIL long_press ph=%0d cyc=%0d got=%b exp=%b", p, cyc, obs, exp_o);
        end
        if (obs[5]) begin n++; at = cyc; end
      end
      checks++;
      if (n != exp_n[p] || (n == 1 && at != 26)) begin
        failures++;
        $display("FAIL long_press_count ph=%0d pulses=%0d edge=%0d exp %0d pulse(s) at edge 26",
                 p, n, at, exp_n[p]);
      end
    end
  endtask

  task automatic test_priority();
    int nr = 0, nt = 0, nd = 0, at = -1;
    bit [6:0] act;
    do_reset();
    for (int c = 0; c < 42; c++) begin
      act = (c < 30) ? 7'b0110000 : 7'b0;
      if (c >= 8 && c < 16) act[3] = 1'b1;
      step(act);
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL priority cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
      if (obs[4]) begin nr++; at = cyc; end
      if (obs[5]) nt++;
      if (obs[3]) nd++;
    end
    checks++;
    if (nr != 1 || at != 26 || nt != 0 || nd != 0) begin
      failures++;
      $display("FAIL priority_pulses reset=%0d@%0d test=%0d div=%0d exp reset=1@26 test=0 div=0",
               nr, at, nt, nd);
    end
  endtask

  task automatic test_ledsign();
    int rise_at = -1, drops = 0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      step((c == 12 || c == 13) ? 7'b0 : 7'b1000000);
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL ledsign cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
      if (obs[6] && rise_at < 0) rise_at = cyc;
      if (!obs[6] && rise_at >= 0) drops++;
    end
    checks++;
    if (rise_at != 5 || drops != 0) begin
      failures++;
      $display("FAIL ledsign_timing rise=%0d drops=%0d exp rise at 5, 0 drops", rise_at, drops);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, at = -1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(7'b0000010);
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
    end
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== 7'b0) begin
        failures++;
        $display("FAIL rst_mid_hold cyc=%0d got=%b exp=%b", c, obs, 7'b0);
      end
    end
    rst_n = 1'b1;
    cyc = -1;
    for (int c = 0; c < 12; c++) begin
      step(7'b0000010);
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL rst_mid_post cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
      if (obs[1]) begin n++; at = cyc; end
    end
    checks++;
    if (n != 1 || at != 6) begin
      failures++;
      $display("FAIL rst_mid_timing pulses=%0d edge=%0d exp 1 pulse at edge 6", n, at);
    end
  endtask

  task automatic test_random();
    bit [6:0] act = '0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int j = 0; j < 7; j++)
        if ($urandom_range(0, (j == 4 || j == 5) ? 30 : 8) == 0) act[j] = ~act[j];
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(act);
      checks++;
      if (obs !== exp_o) begin
        failures++;
        $display("FAIL random cyc=%0d act=%b got=%b exp=%b", cyc, act, obs, exp_o);
      end
    end
  endtask

  initial begin
    drive('0);
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_action();
    test_glitch();
    test_long_press();
    test_priority();
    test_ledsign();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
